// File: rtl/demux_8_capture.sv
// ============================================================================
// Module   : demux_8_capture
// Purpose  : 1-to-8 serial bit demultiplexer with byte capture, idle timeout
//            and overrun flag. Define DEMUX8_MSB_FIRST_EN for MSB-first order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_8_capture #(
  parameter int IDLE_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  input  logic       flush,
  input  logic       dout_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [2:0] lane_sel,
  output logic       overrun,
  output logic       timeout
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;
  localparam logic [7:0] c_timeout_last = 8'(IDLE_TIMEOUT - 1);

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic [2:0] r_lane;
  logic [7:0] r_shift;
  logic [7:0] r_idle_cnt;
  logic [7:0] r_dout;
  logic       r_dout_valid;
  logic       r_overrun;
  logic       r_timeout;

  logic [2:0] w_pos;
  logic [7:0] w_byte;
  logic       w_complete;
  logic       w_timeout_hit;
  logic       w_write;
  logic       w_clear;
  logic       w_count_idle;
  logic       w_load;
  logic       w_drop;

`ifdef DEMUX8_MSB_FIRST_EN
  assign w_pos = 3'd7 - r_lane;
`else
  assign w_pos = r_lane;
`endif

  // The eighth bit is merged combinationally so the byte loads without a bubble.
  assign w_byte        = r_shift | (8'(din) << w_pos);
  assign w_complete    = din_valid && !flush && (r_lane == 3'd7);
  assign w_timeout_hit = (r_state == S_FILL) && !din_valid && !flush &&
                         (r_idle_cnt == c_timeout_last);
  assign w_load        = w_complete && (!r_dout_valid || dout_ready);
  assign w_drop        = w_complete && r_dout_valid && !dout_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (din_valid && !flush) w_state_next = S_FILL;
      S_FILL: if (flush || w_complete || w_timeout_hit) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_write      = 1'b0;
    w_clear      = 1'b0;
    w_count_idle = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_write = din_valid && !flush;
        w_clear = flush;
      end
      S_FILL: begin
        w_write      = din_valid && !flush;
        w_clear      = flush || w_complete || w_timeout_hit;
        w_count_idle = !din_valid && !flush;
      end
      default: w_clear = 1'b1;
    endcase
  end

  // Clearing the shift register at every byte boundary keeps unwritten lanes at 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lane     <= 3'd0;
      r_shift    <= 8'h00;
      r_idle_cnt <= 8'd0;
    end else if (w_clear) begin
      r_lane     <= 3'd0;
      r_shift    <= 8'h00;
      r_idle_cnt <= 8'd0;
    end else if (w_write) begin
      r_lane         <= r_lane + 3'd1;
      r_shift[w_pos] <= din;
      r_idle_cnt     <= 8'd0;
    end else if (w_count_idle) begin
      r_idle_cnt <= r_idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_load) begin
        r_dout       <= w_byte;
        r_dout_valid <= 1'b1;
      end else if (dout_ready) begin
        r_dout_valid <= 1'b0;
      end
      if (flush) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
      r_timeout <= w_timeout_hit;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign lane_sel   = r_lane;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_demux_8_capture.sv
// ============================================================================
// Module   : tb_demux_8_capture
// Purpose  : Directed self-checking bench for demux_8_capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_8_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       flush = 1'b0;
  logic       dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] lane_sel;
  logic       overrun;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  demux_8_capture #(.IDLE_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .flush(flush), .dout_ready(dout_ready), .dout(dout),
    .dout_valid(dout_valid), .lane_sel(lane_sel), .overrun(overrun),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    din = b; din_valid = 1'b1; dout_ready = rdy;
    tick();
  endtask

  // Serialises value so that it should reappear on dout in the configured order.
  task automatic send_byte(input logic [7:0] value, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
`ifdef DEMUX8_MSB_FIRST_EN
      send_bit(value[7-i], (i == 7) ? rdy_last : 1'b0);
`else
      send_bit(value[i], (i == 7) ? rdy_last : 1'b0);
`endif
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    n_checks++; if (lane_sel !== 3'd0) begin n_fail++; $display("FAIL reset_lane got=%0d exp=0", lane_sel); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_byte();
    logic [7:0] bits;
    logic [7:0] exp_byte;
    bits = 8'b0100_1101; // bits[i] is the i-th serial bit: 1,0,1,1,0,0,1,0
`ifdef DEMUX8_MSB_FIRST_EN
    exp_byte = 8'hB2;
`else
    exp_byte = 8'h4D;
`endif
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[i], 1'b1);
      n_checks++;
      if (lane_sel !== 3'((i + 1) % 8)) begin
        n_fail++; $display("FAIL byte_lane[%0d] got=%0d exp=%0d", i, lane_sel, (i + 1) % 8);
      end
    end
    idle_inputs();
    dout_ready = 1'b1;
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL byte_valid got=%b exp=1", dout_valid); end
    n_checks++; if (dout !== exp_byte) begin n_fail++; $display("FAIL byte_dout got=%h exp=%h", dout, exp_byte); end
    tick();
    idle_inputs();
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL byte_valid_clear got=%b exp=0", dout_valid); end
  endtask

  task automatic test_overrun();
    send_byte(8'hFF, 1'b0);
    n_checks++; if (dout_valid !== 1'b1 || dout !== 8'hFF) begin
      n_fail++; $display("FAIL ovr_first got=%b/%h exp=1/ff", dout_valid, dout);
    end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    send_byte(8'h00, 1'b0);
    n_checks++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL ovr_held_dout got=%h exp=ff", dout); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    tick(); tick();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    flush = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_flush got=%b exp=0", overrun); end
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_flush_valid got=%b exp=1", dout_valid); end
    dout_ready = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume got=%b exp=0", dout_valid); end
    dout_ready = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (dout_valid !== 1'b0 || dout !== 8'hFF) begin
      n_fail++; $display("FAIL ovr_ready_idle got=%b/%h exp=0/ff", dout_valid, dout);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'hA5, 1'b1);
    n_checks++; if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
      n_fail++; $display("FAIL b2b_first got=%b/%h exp=1/a5", dout_valid, dout);
    end
    // Second byte completes while the first is still held; ready on that same cycle.
    send_byte(8'h3C, 1'b1);
    n_checks++; if (dout_valid !== 1'b1 || dout !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_second got=%b/%h exp=1/3c", dout_valid, dout);
    end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    dout_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    idle_inputs();
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++;
      if (timeout !== 1'b0 || lane_sel !== 3'd3) begin
        n_fail++; $display("FAIL tmo_idle[%0d] got=%b/%0d exp=0/3", k, timeout, lane_sel);
      end
    end
    tick();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse got=%b exp=1", timeout); end
    n_checks++; if (lane_sel !== 3'd0) begin n_fail++; $display("FAIL tmo_lane got=%0d exp=0", lane_sel); end
    tick();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_one_cycle got=%b exp=0", timeout); end
    send_byte(8'h81, 1'b1);
    n_checks++; if (dout_valid !== 1'b1 || dout !== 8'h81) begin
      n_fail++; $display("FAIL tmo_clean got=%b/%h exp=1/81", dout_valid, dout);
    end
    dout_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    n_checks++; if (lane_sel !== 3'd5) begin n_fail++; $display("FAIL fl_pre_lane got=%0d exp=5", lane_sel); end
    din = 1'b1; din_valid = 1'b1; flush = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (lane_sel !== 3'd0) begin n_fail++; $display("FAIL fl_lane got=%0d exp=0", lane_sel); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL fl_timeout got=%b exp=0", timeout); end
    n_checks++; if (dout_valid !== 1'b1 || dout !== 8'h5A) begin
      n_fail++; $display("FAIL fl_hold got=%b/%h exp=1/5a", dout_valid, dout);
    end
    send_byte(8'h0F, 1'b1);
    n_checks++; if (dout !== 8'h0F || overrun !== 1'b0) begin
      n_fail++; $display("FAIL fl_next got=%h/%b exp=0f/0", dout, overrun);
    end
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b1;
    tick();
    idle_inputs();
    send_byte(8'hC3, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
    n_checks++; if (lane_sel !== 3'd6 || dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL rm_pre got=%0d/%b exp=6/1", lane_sel, dout_valid);
    end
    reset = 1'b1; din = 1'b1; din_valid = 1'b1; flush = 1'b1; dout_ready = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    n_checks++; if (dout !== 8'h00 || dout_valid !== 1'b0 || lane_sel !== 3'd0 ||
                    overrun !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL rm_clear got=%h/%b/%0d/%b/%b exp=00/0/0/0/0",
                         dout, dout_valid, lane_sel, overrun, timeout);
    end
    send_byte(8'h96, 1'b1);
    n_checks++; if (dout !== 8'h96) begin n_fail++; $display("FAIL rm_after got=%h exp=96", dout); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
